lhn_div11_seq: RTL and testbench



---
 rtl/lhn_div_pkg.sv | 17 +
 rtl/lhn_div_step.sv | 27 ++
 rtl/lhn_div11_seq.sv | 127 ++++++++++++
 tb/tb_lhn_div11_seq.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/lhn_div_pkg.sv
// Shared constants and state encoding for the 11-bit restoring divider.
// The divider runs beside the 11-bit multiplier emulator in the ALU datapath.
package lhn_div_pkg;

    localparam int DVD_W = 11;
    localparam int DVS_W = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Quotient reported when the divisor is zero.
    localparam logic [DVD_W-1:0] QUO_ALL_ONES = '1;

endpackage

// File: rtl/lhn_div_step.sv
// One restoring-division step: shift in a dividend bit, then subtract the divisor when it fits.
// Purely combinational.
module lhn_div_step #(
    parameter int DVS_W = 5
) (
    input  logic [DVS_W-1:0] prem_i,
    input  logic             bit_i,
    input  logic [DVS_W-1:0] divisor_i,
    output logic [DVS_W-1:0] prem_o,
    output logic             q_bit_o
);

    logic [DVS_W:0] p;

    always_comb begin
        p = {prem_i, bit_i};
        // The extra top bit of p catches the shifted-out MSB, so compare at DVS_W+1 bits.
        if (p >= {1'b0, divisor_i}) begin
            q_bit_o = 1'b1;
            prem_o  = DVS_W'(p - {1'b0, divisor_i});
        end else begin
            q_bit_o = 1'b0;
            prem_o  = p[DVS_W-1:0];
        end
    end

endmodule

// File: rtl/lhn_div11_seq.sv
// Sequential restoring divider: one quotient bit per clock, start/busy/done handshake.
// Divide by zero finishes immediately with an all-ones quotient and the error flag set.
module lhn_div11_seq #(
    parameter int DVD_W = lhn_div_pkg::DVD_W,
    parameter int DVS_W = lhn_div_pkg::DVS_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [DVD_W-1:0] dividend,
    input  logic [DVS_W-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [DVD_W-1:0] quotient,
    output logic [DVS_W-1:0] remainder,
    output logic             div_by_zero
);

    import lhn_div_pkg::*;

    localparam int CNT_W = $clog2(DVD_W);

    state_e             state_q,     state_d;
    logic [CNT_W-1:0]   count_q,     count_d;
    logic [DVD_W-1:0]   dvd_q,       dvd_d;
    logic [DVS_W-1:0]   dvs_q,       dvs_d;
    logic [DVS_W-1:0]   prem_q,      prem_d;
    logic [DVD_W-2:0]   quo_sh_q,    quo_sh_d;
    logic [DVD_W-1:0]   quotient_q,  quotient_d;
    logic [DVS_W-1:0]   remainder_q, remainder_d;
    logic               dbz_q,       dbz_d;

    logic [DVS_W-1:0]   step_prem;
    logic               step_bit;

    // The dividend register shifts left each step, so its MSB is always the next bit.
    lhn_div_step #(
        .DVS_W (DVS_W)
    ) u_step (
        .prem_i    (prem_q),
        .bit_i     (dvd_q[DVD_W-1]),
        .divisor_i (dvs_q),
        .prem_o    (step_prem),
        .q_bit_o   (step_bit)
    );

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        dvd_d       = dvd_q;
        dvs_d       = dvs_q;
        prem_d      = prem_q;
        quo_sh_d    = quo_sh_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (divisor != '0) begin
                        dvd_d   = dividend;
                        dvs_d   = divisor;
                        prem_d  = '0;
                        count_d = CNT_W'(DVD_W - 1);
                        state_d = RUN;
                    end else begin
                        quotient_d  = QUO_ALL_ONES;
                        remainder_d = '0;
                        dbz_d       = 1'b1;
                        state_d     = DONE;
                    end
                end
            end
            RUN: begin
                prem_d   = step_prem;
                dvd_d    = dvd_q << 1;
                quo_sh_d = {quo_sh_q[DVD_W-3:0], step_bit};
                if (count_q == '0) begin
                    quotient_d  = {quo_sh_q, step_bit};
                    remainder_d = step_prem;
                    dbz_d       = 1'b0;
                    state_d     = DONE;
                end else begin
                    count_d = count_q - CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            count_q     <= '0;
            dvd_q       <= '0;
            dvs_q       <= '0;
            prem_q      <= '0;
            quo_sh_q    <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            dvd_q       <= dvd_d;
            dvs_q       <= dvs_d;
            prem_q      <= prem_d;
            quo_sh_q    <= quo_sh_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
        end
    end

    assign busy        = (state_q != IDLE);
    assign done        = (state_q == DONE);
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_lhn_div11_seq.sv
// Directed bench for the sequential divider: latency, results, divide by zero,
// start held during RUN, and reset in mid-operation.
module tb_lhn_div11_seq;

    logic        clock;
    logic        reset;
    logic        start;
    logic [10:0] dividend;
    logic [4:0]  divisor;
    logic        busy;
    logic        done;
    logic [10:0] quotient;
    logic [4:0]  remainder;
    logic        div_by_zero;

    int pass_cnt  = 0;
    int total_cnt = 0;

    lhn_div11_seq dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    // Presents operands with start high across one edge (E0), then drops start.
    task automatic launch(input logic [10:0] a, input logic [4:0] b);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    // Edges counted from E0 (inclusive) until done is seen; -1 on timeout.
    task automatic wait_done(output int edges);
        int e;
        edges = -1;
        e = 1;
        for (int i = 0; i < 30; i++) begin
            if (done) begin
                edges = e;
                break;
            end
            tick();
            e++;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        start = 1'b0;
        dividend = '0;
        divisor  = '0;
        tick();
        tick();
        reset = 1'b0;
        total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else pass_cnt++;
        total_cnt++; if (done !== 1'b0) $display("FAIL reset_done got=%b exp=0", done); else pass_cnt++;
        total_cnt++; if (quotient !== 11'd0) $display("FAIL reset_quot got=%0d exp=0", quotient); else pass_cnt++;
        total_cnt++; if (remainder !== 5'd0) $display("FAIL reset_rem got=%0d exp=0", remainder); else pass_cnt++;
        total_cnt++; if (div_by_zero !== 1'b0) $display("FAIL reset_dbz got=%b exp=0", div_by_zero); else pass_cnt++;
        $display("reset: busy=%b done=%b q=%0d r=%0d dbz=%b", busy, done, quotient, remainder, div_by_zero);
    endtask

    task automatic test_basic;
        int n;
        launch(11'd100, 5'd12);
        total_cnt++; if (busy !== 1'b1) $display("FAIL basic_busy_after_e0 got=%b exp=1", busy); else pass_cnt++;
        wait_done(n);
        total_cnt++; if (n !== 12) $display("FAIL basic_latency got=%0d exp=12", n); else pass_cnt++;
        total_cnt++; if (quotient !== 11'd8) $display("FAIL basic_quot got=%0d exp=8", quotient); else pass_cnt++;
        total_cnt++; if (remainder !== 5'd4) $display("FAIL basic_rem got=%0d exp=4", remainder); else pass_cnt++;
        total_cnt++; if (div_by_zero !== 1'b0) $display("FAIL basic_dbz got=%b exp=0", div_by_zero); else pass_cnt++;
        $display("op 100/12: edges=%0d q=%0d r=%0d dbz=%b", n, quotient, remainder, div_by_zero);
        tick();
        total_cnt++; if (done !== 1'b0) $display("FAIL basic_done_pulse got=%b exp=0", done); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL basic_busy_end got=%b exp=0", busy); else pass_cnt++;
        total_cnt++; if (quotient !== 11'd8) $display("FAIL basic_quot_held got=%0d exp=8", quotient); else pass_cnt++;
    endtask

    task automatic test_values;
        int n;
        launch(11'd2047, 5'd31);
        wait_done(n);
        total_cnt++; if (quotient !== 11'd66) $display("FAIL max_quot got=%0d exp=66", quotient); else pass_cnt++;
        total_cnt++; if (remainder !== 5'd1) $display("FAIL max_rem got=%0d exp=1", remainder); else pass_cnt++;
        $display("op 2047/31: edges=%0d q=%0d r=%0d", n, quotient, remainder);
        tick();
        launch(11'd5, 5'd7);
        wait_done(n);
        total_cnt++; if (quotient !== 11'd0) $display("FAIL small_quot got=%0d exp=0", quotient); else pass_cnt++;
        total_cnt++; if (remainder !== 5'd5) $display("FAIL small_rem got=%0d exp=5", remainder); else pass_cnt++;
        $display("op 5/7: edges=%0d q=%0d r=%0d", n, quotient, remainder);
        tick();
    endtask

    task automatic test_div_zero;
        int n;
        launch(11'd500, 5'd0);
        total_cnt++; if (done !== 1'b1) $display("FAIL dbz_done_latency got=%b exp=1", done); else pass_cnt++;
        total_cnt++; if (quotient !== 11'h7FF) $display("FAIL dbz_quot got=%h exp=7ff", quotient); else pass_cnt++;
        total_cnt++; if (remainder !== 5'd0) $display("FAIL dbz_rem got=%0d exp=0", remainder); else pass_cnt++;
        total_cnt++; if (div_by_zero !== 1'b1) $display("FAIL dbz_flag got=%b exp=1", div_by_zero); else pass_cnt++;
        $display("op 500/0: done=%b q=%h r=%0d dbz=%b", done, quotient, remainder, div_by_zero);
        tick();
        total_cnt++; if (busy !== 1'b0) $display("FAIL dbz_idle got=%b exp=0", busy); else pass_cnt++;
        launch(11'd60, 5'd12);
        wait_done(n);
        total_cnt++; if (n !== 12) $display("FAIL after_dbz_latency got=%0d exp=12", n); else pass_cnt++;
        total_cnt++; if (quotient !== 11'd5) $display("FAIL after_dbz_quot got=%0d exp=5", quotient); else pass_cnt++;
        total_cnt++; if (remainder !== 5'd0) $display("FAIL after_dbz_rem got=%0d exp=0", remainder); else pass_cnt++;
        total_cnt++; if (div_by_zero !== 1'b0) $display("FAIL after_dbz_flag got=%b exp=0", div_by_zero); else pass_cnt++;
        $display("op 60/12: edges=%0d q=%0d r=%0d dbz=%b", n, quotient, remainder, div_by_zero);
        tick();
    endtask

    task automatic test_back_to_back;
        int n;
        dividend = 11'd100;
        divisor  = 5'd12;
        start    = 1'b1;
        tick();
        dividend = 11'd1386;
        divisor  = 5'd12;
        wait_done(n);
        total_cnt++; if (n !== 12) $display("FAIL b2b_latency got=%0d exp=12", n); else pass_cnt++;
        total_cnt++; if (quotient !== 11'd8) $display("FAIL b2b_first_quot got=%0d exp=8", quotient); else pass_cnt++;
        total_cnt++; if (remainder !== 5'd4) $display("FAIL b2b_first_rem got=%0d exp=4", remainder); else pass_cnt++;
        $display("op 100/12 (start held): edges=%0d q=%0d r=%0d", n, quotient, remainder);
        tick();
        total_cnt++; if (busy !== 1'b0) $display("FAIL b2b_start_in_done_ignored got=%b exp=0", busy); else pass_cnt++;
        tick();
        start = 1'b0;
        total_cnt++; if (busy !== 1'b1) $display("FAIL b2b_second_accept got=%b exp=1", busy); else pass_cnt++;
        total_cnt++; if (quotient !== 11'd8) $display("FAIL b2b_held_during_run got=%0d exp=8", quotient); else pass_cnt++;
        wait_done(n);
        total_cnt++; if (n !== 12) $display("FAIL b2b_second_latency got=%0d exp=12", n); else pass_cnt++;
        total_cnt++; if (quotient !== 11'd115) $display("FAIL b2b_second_quot got=%0d exp=115", quotient); else pass_cnt++;
        total_cnt++; if (remainder !== 5'd6) $display("FAIL b2b_second_rem got=%0d exp=6", remainder); else pass_cnt++;
        $display("op 1386/12 (second): edges=%0d q=%0d r=%0d", n, quotient, remainder);
        tick();
    endtask

    task automatic test_reset_mid_run;
        int n;
        int seen_done;
        launch(11'd100, 5'd12);
        repeat (4) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        total_cnt++; if (busy !== 1'b0) $display("FAIL abort_busy got=%b exp=0", busy); else pass_cnt++;
        total_cnt++; if (done !== 1'b0) $display("FAIL abort_done got=%b exp=0", done); else pass_cnt++;
        total_cnt++; if (quotient !== 11'd0) $display("FAIL abort_quot got=%0d exp=0", quotient); else pass_cnt++;
        total_cnt++; if (remainder !== 5'd0) $display("FAIL abort_rem got=%0d exp=0", remainder); else pass_cnt++;
        total_cnt++; if (div_by_zero !== 1'b0) $display("FAIL abort_dbz got=%b exp=0", div_by_zero); else pass_cnt++;
        seen_done = 0;
        for (int i = 0; i < 15; i++) begin
            if (done) seen_done++;
            tick();
        end
        total_cnt++; if (seen_done !== 0) $display("FAIL abort_no_done got=%0d exp=0", seen_done); else pass_cnt++;
        $display("abort at step 5: busy=%b done_pulses=%0d", busy, seen_done);
        launch(11'd1386, 5'd12);
        wait_done(n);
        total_cnt++; if (quotient !== 11'd115) $display("FAIL fresh_quot got=%0d exp=115", quotient); else pass_cnt++;
        total_cnt++; if (remainder !== 5'd6) $display("FAIL fresh_rem got=%0d exp=6", remainder); else pass_cnt++;
        $display("op 1386/12 (after abort): edges=%0d q=%0d r=%0d", n, quotient, remainder);
        tick();
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        test_reset();
        test_basic();
        test_values();
        test_div_zero();
        test_back_to_back();
        test_reset_mid_run();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
